tlp_requester: RTL

TLP_REQUESTER -- requirements
Module: tlp_requester

---
 rtl/tlp_requester.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tlp_requester.sv
// Single-outstanding PCIe memory requester: serialises MRd/MWr TLPs onto a
// 16-bit transmit port and matches the returning completion for reads.
module tlp_requester #(
  parameter logic [15:0] CPL_TIMEOUT = 16'd50000,
  parameter int          TAG_BITS    = 5
) (
  input  logic        clk_125,
  input  logic        core_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [61:0] cmd_addr,
  input  logic [3:0]  cmd_firstbe,
  input  logic [31:0] cmd_wdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_err,
  input  logic [7:0]  bus_num,
  input  logic [4:0]  dev_num,
  input  logic [2:0]  func_num,
  input  logic [8:0]  tx_ca_ph,
  input  logic [12:0] tx_ca_pd,
  input  logic [8:0]  tx_ca_nph,
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data
);

  typedef enum logic [2:0] {IDLE, CREDIT, REQ, SEND, WAIT_CPL} state_t;
  state_t state_q, state_d;

  logic                ready_en;
  logic                wr_q;
  logic [61:0]         addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic [TAG_BITS-1:0] tag_q, out_tag_q;
  logic [3:0]          wcnt_q;
  logic [15:0]         tmo_q;
  logic                rx_act_q;
  logic [3:0]          rx_cnt_q;
  logic [6:0]          w0_q;
  logic [2:0]          stat_q;
  logic [7:0]          rtag_q;
  logic [15:0]         dhi_q, dlo_q;

  logic        accept, is64, last, credit_ok, match, timeout, cpl_err;
  logic [63:0] full_addr;
  logic [3:0]  last_idx, wsel, rx_idx;
  logic        rx_live;
  logic [6:0]  w0_c;
  logic [2:0]  stat_c;
  logic [7:0]  rtag_c;
  logic [15:0] dhi_c, dlo_c;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = ready_en && (state_q == IDLE);
  assign tx_req    = (state_q == REQ);
  assign is64      = |addr_q[61:30];
  assign full_addr = {addr_q, 2'b00};
  assign last_idx  = 4'd5 + (is64 ? 4'd2 : 4'd0) + (wr_q ? 4'd2 : 4'd0);
  // 32-bit TLPs skip the two upper-address words of the 64-bit layout
  assign wsel      = (is64 || wcnt_q < 4'd4) ? wcnt_q : wcnt_q + 4'd2;
  assign last      = (state_q == SEND) && (wcnt_q == last_idx);
  assign tx_st     = (state_q == SEND) && (wcnt_q == 4'd0);
  assign tx_end    = last;
  assign credit_ok = wr_q ? ((|tx_ca_ph) && (|tx_ca_pd)) : (|tx_ca_nph);

  always_comb begin
    tx_data = '0;
    if (state_q == SEND) begin
      case (wsel)
        4'd0:    tx_data = {1'b0, wr_q, is64, 5'b00000, 1'b0, 3'b000, 4'b0000};
        4'd1:    tx_data = 16'h0001;
        4'd2:    tx_data = {bus_num, dev_num, func_num};
        4'd3:    tx_data = {8'(tag_q), 4'b0000, be_q};
        4'd4:    tx_data = full_addr[63:48];
        4'd5:    tx_data = full_addr[47:32];
        4'd6:    tx_data = full_addr[31:16];
        4'd7:    tx_data = full_addr[15:0];
        4'd8:    tx_data = wdata_q[31:16];
        4'd9:    tx_data = wdata_q[15:0];
        default: tx_data = '0;
      endcase
    end
  end

  // Receive parser: the _c values fold in the word on the wire this cycle so
  // the decision at rx_end sees the complete header without an extra stage.
  assign rx_live = rx_st || rx_act_q;
  assign rx_idx  = rx_st ? 4'd0 : rx_cnt_q;
  assign w0_c    = rx_st ? rx_data[14:8] : w0_q;
  assign stat_c  = (rx_live && rx_idx == 4'd3) ? rx_data[15:13] : stat_q;
  assign rtag_c  = (rx_live && rx_idx == 4'd5) ? rx_data[15:8]  : rtag_q;
  assign dhi_c   = (rx_live && rx_idx == 4'd6) ? rx_data : dhi_q;
  assign dlo_c   = (rx_live && rx_idx == 4'd7) ? rx_data : dlo_q;
  assign cpl_err = (stat_c != 3'b000) || !w0_c[6];
  assign match   = (state_q == WAIT_CPL) && rx_live && rx_end && (rx_idx >= 4'd5) &&
                   (w0_c[4:0] == 5'b01010) && (rtag_c == 8'(out_tag_q));
  assign timeout = (state_q == WAIT_CPL) && (tmo_q == CPL_TIMEOUT - 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = CREDIT;
      CREDIT:   if (credit_ok) state_d = REQ;
      REQ:      if (tx_rdy) state_d = SEND;
      SEND:     if (last) state_d = wr_q ? IDLE : WAIT_CPL;
      WAIT_CPL: if (match || timeout) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_125 or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q   <= IDLE;
      ready_en  <= 1'b0;
      tag_q     <= '0;
      out_tag_q <= '0;
      wcnt_q    <= '0;
      tmo_q     <= '0;
      rx_act_q  <= 1'b0;
      rx_cnt_q  <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      state_q  <= state_d;
      ready_en <= 1'b1;
      wcnt_q   <= (state_q == SEND) ? wcnt_q + 4'd1 : 4'd0;
      tmo_q    <= (state_q == WAIT_CPL) ? tmo_q + 16'd1 : 16'd0;
      if (last && !wr_q) begin
        out_tag_q <= tag_q;
        tag_q     <= tag_q + 1'b1;
      end
      if (rx_st) begin
        rx_act_q <= !rx_end;
        rx_cnt_q <= 4'd1;
      end else if (rx_act_q) begin
        if (rx_end) rx_act_q <= 1'b0;
        if (rx_cnt_q != 4'hF) rx_cnt_q <= rx_cnt_q + 4'd1;
      end
      rd_valid <= 1'b0;
      if (match) begin
        rd_valid <= 1'b1;
        rd_err   <= cpl_err;
        rd_data  <= cpl_err ? 32'hFFFF_FFFF : {dhi_c, dlo_c};
      end else if (timeout) begin
        rd_valid <= 1'b1;
        rd_err   <= 1'b1;
        rd_data  <= 32'hFFFF_FFFF;
      end
    end
  end

  always_ff @(posedge clk_125) begin
    if (accept) begin
      wr_q    <= cmd_write;
      addr_q  <= cmd_addr;
      be_q    <= cmd_firstbe;
      wdata_q <= cmd_wdata;
    end
    w0_q   <= w0_c;
    stat_q <= stat_c;
    rtag_q <= rtag_c;
    dhi_q  <= dhi_c;
    dlo_q  <= dlo_c;
  end

endmodule
